// File: rtl/spi_servo_slave.sv
// SPI mode-0 responder. SCLK/CS_N/MOSI are oversampled in the system clock domain.
// 16-bit frames {rw, addr[6:0]}, {data} read or write a small byte register file.
`timescale 1ns/1ps
module spi_servo_slave #(
    parameter int         NUM_REGS  = 8,
    parameter logic [7:0] RESET_VAL = 8'h80
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_spi_sclk,
    input  logic                  i_spi_cs_n,
    input  logic                  i_spi_mosi,
    output logic                  o_spi_miso,
    output logic                  o_spi_miso_oe,
    output logic [NUM_REGS*8-1:0] o_reg_out,
    output logic                  o_wr_strobe,
    output logic [6:0]            o_wr_addr,
    output logic                  o_frame_err
);

    localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_WAIT_CS} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_sclk_meta, r_sclk_sync, r_sclk_d;
    logic        r_cs_meta, r_cs_sync, r_cs_d;
    logic        r_mosi_meta, r_mosi_sync;
    logic [3:0]  r_bit_cnt;
    logic [6:0]  r_rx_shift;
    logic [7:0]  r_tx_shift;
    logic        r_rw;
    logic [6:0]  r_addr;
    logic        r_addr_ok;
    logic        r_miso;
    logic        r_wr_strobe;
    logic [6:0]  r_wr_addr;
    logic        r_frame_err;
    logic [7:0]  r_regs [NUM_REGS];

    logic        w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic        w_abort, w_cmd_done, w_commit;
    logic [7:0]  w_rx_byte;
    logic        w_cmd_addr_ok;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_d    <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_d      <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_sclk_meta <= i_spi_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_d    <= r_sclk_sync;
            r_cs_meta   <= i_spi_cs_n;
            r_cs_sync   <= r_cs_meta;
            r_cs_d      <= r_cs_sync;
            r_mosi_meta <= i_spi_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_sclk_rise   = r_sclk_sync & ~r_sclk_d;
    assign w_sclk_fall   = ~r_sclk_sync & r_sclk_d;
    assign w_cs_rise     = r_cs_sync & ~r_cs_d;
    assign w_cs_fall     = ~r_cs_sync & r_cs_d;
    assign w_rx_byte     = {r_rx_shift, r_mosi_sync};
    assign w_cmd_addr_ok = ({1'b0, w_rx_byte[6:0]} < NUM_REGS_B);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        w_cmd_done   = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) w_state_next = ST_CMD;
            end
            ST_CMD: begin
                if (w_cs_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_sclk_rise && r_bit_cnt == 4'd7) begin
                    w_cmd_done   = 1'b1;
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_cs_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_sclk_rise && r_bit_cnt == 4'd15) begin
                    w_commit     = 1'b1;
                    w_state_next = ST_WAIT_CS;
                end
            end
            ST_WAIT_CS: begin
                if (w_cs_rise) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt   <= 4'd0;
            r_rx_shift  <= 7'd0;
            r_tx_shift  <= 8'd0;
            r_rw        <= 1'b0;
            r_addr      <= 7'd0;
            r_addr_ok   <= 1'b0;
            r_miso      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 7'd0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
        end else begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= w_abort;

            if (r_state == ST_IDLE && w_cs_fall) begin
                r_bit_cnt <= 4'd0;
                r_miso    <= 1'b0;
            end

            if ((r_state == ST_CMD || r_state == ST_DATA) && w_sclk_rise && !w_cs_rise) begin
                r_bit_cnt  <= r_bit_cnt + 4'd1;
                r_rx_shift <= w_rx_byte[6:0];
            end

            // Out-of-range reads shift out zeros rather than aliasing into the file.
            if (w_cmd_done) begin
                r_rw       <= w_rx_byte[7];
                r_addr     <= w_rx_byte[6:0];
                r_addr_ok  <= w_cmd_addr_ok;
                r_tx_shift <= (w_rx_byte[7] && w_cmd_addr_ok) ? r_regs[w_rx_byte[AW-1:0]] : 8'h00;
            end

            if (r_state == ST_DATA && w_sclk_fall && r_rw) begin
                r_miso     <= r_tx_shift[7];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end

            if (w_commit) begin
                r_miso <= 1'b0;
                if (!r_rw && r_addr_ok) begin
                    r_regs[r_addr[AW-1:0]] <= w_rx_byte;
                    r_wr_strobe            <= 1'b1;
                    r_wr_addr              <= r_addr;
                end
            end

            if (w_abort) r_miso <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
            assign o_reg_out[gi*8 +: 8] = r_regs[gi];
        end
    endgenerate

    assign o_spi_miso    = r_miso;
    assign o_spi_miso_oe = ~r_cs_sync;
    assign o_wr_strobe   = r_wr_strobe;
    assign o_wr_addr     = r_wr_addr;
    assign o_frame_err   = r_frame_err;

endmodule
